branch_prediction: RTL and testbench
====================================

Name: branch_prediction

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Sits upstream of the PC register: looks up the current fetch PC combinationally and drives pre_branch_flag_o / pre_branch_target_address_o, which the PC register uses when no resolved branch is pending.
- Trained by the decode stage's branch resolution.
- Keeps wrapping performance counters for lookups, hits and mispredictions.

Parameters:
- INDEX_W, 4: BTB index width; ENTRIES = 2**INDEX_W.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  fetch enable from the PC register; when 0, no prediction is made and no lookup is counted.
- pc_i  in  32  current fetch address; word-aligned.
- stall_i  in  1  stall[0] from the stall controller; when 1, no lookup is counted.
- pre_branch_flag_o  out  1  predicted taken.
- pre_branch_target_address_o  out  32  predicted target; 0 when flag is 0.
- upd_valid_i  in  1  one resolved branch or jump this cycle.
- upd_pc_i  in  32  address of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  32  actual target; valid when taken.
- upd_pred_taken_i  in  1  prediction that was made for this branch, carried down the pipeline.
- upd_pred_target_i  in  32  predicted target, carried down the pipeline.
- perf_clr_i  in  1  synchronous clear of the performance counters.
- lookup_cnt_o  out  CNT_W  counted lookups.
- hit_cnt_o  out  CNT_W  lookups that hit a valid entry.
- mispred_cnt_o  out  CNT_W  mispredicted updates.

Behaviour:
- Address split:
  - idx = pc[INDEX_W+1:2]; tag = pc[31:INDEX_W+2]; pc[1:0] is ignored.
  - Each entry holds valid, tag, target[31:0] and cnt[1:0].
- Lookup (combinational, zero latency):
  - hit = ce & valid[idx] & (tag[idx] == pc tag).
  - pre_branch_flag_o = hit & cnt[idx][1].
  - pre_branch_target_address_o = target[idx] when the flag is 1, else 32'h0.
- Update (on the clock edge when upd_valid_i = 1):
  - Entry hit, taken: cnt saturating-increments (max 2'b11); target <= upd_target_i.
  - Entry hit, not taken: cnt saturating-decrements (min 2'b00); the entry stays valid.
  - Entry miss, taken: allocate. valid <= 1, tag and target written, cnt <= 2'b10 (weakly taken). Any prior occupant is overwritten.
  - Entry miss, not taken: no change.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no write-to-read bypass.
- Misprediction (counted only when upd_valid_i = 1) is either:
  - upd_pred_taken_i != upd_taken_i, or
  - both taken and upd_pred_target_i != upd_target_i.
- Performance counters:
  - lookup_cnt increments when ce & ~stall_i.
  - hit_cnt increments when ce & ~stall_i & hit.
  - mispred_cnt increments on a misprediction.
  - All wrap modulo 2**CNT_W.
  - perf_clr_i has priority over increments in the same cycle.
- Reset (rst = 0, asynchronous): all valid bits, tags, targets and cnt = 0; all perf counters = 0.
  - Outputs: pre_branch_flag_o = 0, pre_branch_target_address_o = 0.
  - A reset mid-update discards the update.
- Update is independent of stall_i; decode-stage resolution may arrive while fetch is stalled.

Decomposition:
- Shared defines file, new constants: BtbIndexW, CntStrongNT 2'b00, CntWeakNT 2'b01, CntWeakT 2'b10, CntStrongT 2'b11, PredTaken 1'b1. Existing RegBus / InstAddrBus widths are reused.
- One natural sub-module, sat_counter2: a 2-bit saturating increment/decrement function or module, used per update.
- The BTB arrays stay inline as register arrays; no SRAM macro.

Test Plan:
- Reset, then ce=1, pc_i=32'h100 -> pre_branch_flag_o=0, target=0, lookup_cnt=1 after one unstalled cycle, hit_cnt=0.
- Train the branch at 32'h100: taken to 32'h200 with pred_taken=0, then lookup 32'h100 -> flag=1, target=32'h200, cnt=2'b10, mispred_cnt=1.
- Counter saturation at 32'h100:
  - Two more taken updates -> cnt=2'b11.
  - Then three not-taken updates -> cnt 2'b10, 2'b01, 2'b00.
  - Lookup gives flag=0 after the second not-taken update; the entry stays valid, so hit_cnt still increments.
- Aliasing: an entry exists for 32'h100; a taken update at 32'h140 (same idx 0, different tag) to 32'h300 replaces it -> lookup 32'h100 misses with flag=0, lookup 32'h140 gives flag=1, target 32'h300.
- Same-cycle conflict: pc_i=32'h100 while the update allocates at 32'h100 -> that cycle flag=0; next cycle flag=1.
- Mid-operation reset and clear precedence:
  - Drop rst during a valid update -> all outputs and counters 0 immediately; the entry is not written.
  - perf_clr_i together with an increment -> counters read 0 next cycle.

Source files
------------

// File: rtl/branch_prediction_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : branch_prediction_pkg                                            |
// | Brief   : Shared widths, BTB direction-counter encodings and helpers.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package branch_prediction_pkg;

  localparam int RegBus      = 32;
  localparam int InstAddrBus = 32;
  localparam int BtbIndexW   = 4;

  localparam logic [1:0] CntStrongNT = 2'b00;
  localparam logic [1:0] CntWeakNT   = 2'b01;
  localparam logic [1:0] CntWeakT    = 2'b10;
  localparam logic [1:0] CntStrongT  = 2'b11;
  localparam logic       PredTaken   = 1'b1;

  typedef logic [InstAddrBus-1:0] inst_addr_t;

  // A taken branch that went to the wrong place is as costly as a wrong direction.
  function automatic logic is_mispredict(input logic       pred_taken,
                                         input inst_addr_t pred_target,
                                         input logic       taken,
                                         input inst_addr_t target);
    logic dir_wrong;
    logic tgt_wrong;
    dir_wrong = (pred_taken != taken);
    tgt_wrong = (taken == PredTaken) && (pred_taken == PredTaken) && (pred_target != target);
    return dir_wrong | tgt_wrong;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_prediction_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : branch_prediction_if                                             |
// | Brief   : Fetch lookup, decode training and perf-counter signal bundle.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface branch_prediction_if #(
  parameter int CNT_W = 32
);
  import branch_prediction_pkg::*;

  logic             ce;
  inst_addr_t       pc_i;
  logic             stall_i;
  logic             pre_branch_flag_o;
  inst_addr_t       pre_branch_target_address_o;

  logic             upd_valid_i;
  inst_addr_t       upd_pc_i;
  logic             upd_taken_i;
  inst_addr_t       upd_target_i;
  logic             upd_pred_taken_i;
  inst_addr_t       upd_pred_target_i;

  logic             perf_clr_i;
  logic [CNT_W-1:0] lookup_cnt_o;
  logic [CNT_W-1:0] hit_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output ce, pc_i, stall_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    output upd_pred_taken_i, upd_pred_target_i, perf_clr_i,
    input  pre_branch_flag_o, pre_branch_target_address_o,
    input  lookup_cnt_o, hit_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  ce, pc_i, stall_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  upd_pred_taken_i, upd_pred_target_i, perf_clr_i,
    output pre_branch_flag_o, pre_branch_target_address_o,
    output lookup_cnt_o, hit_cnt_o, mispred_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/branch_prediction_sat_counter2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : branch_prediction_sat_counter2                                   |
// | Brief   : 2-bit saturating up/down direction counter (next-state only).    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module branch_prediction_sat_counter2
  import branch_prediction_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       up,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    unique case (cnt)
      CntStrongNT: cnt_next = up ? CntWeakNT  : CntStrongNT;
      CntWeakNT:   cnt_next = up ? CntWeakT   : CntStrongNT;
      CntWeakT:    cnt_next = up ? CntStrongT : CntWeakNT;
      CntStrongT:  cnt_next = up ? CntStrongT : CntWeakT;
      default:     cnt_next = cnt;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_prediction.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : branch_prediction                                                |
// | Brief   : Direct-mapped BTB with 2-bit counters and perf counters.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module branch_prediction
  import branch_prediction_pkg::*;
#(
  parameter int INDEX_W = BtbIndexW,
  parameter int CNT_W   = RegBus
) (
  input  logic               clk,
  input  logic               rst,
  branch_prediction_if.slave bp
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int TAG_W   = InstAddrBus - INDEX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  inst_addr_t       r_target [ENTRIES];
  logic [1:0]       r_cnt    [ENTRIES];

  logic [CNT_W-1:0] r_lookup_cnt;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [INDEX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic               w_pred_taken;
  logic               w_lookup_fire;

  logic [INDEX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;
  logic [1:0]         w_upd_cnt_next;
  logic               w_mispred;

  logic               w_unused;

  // Fetch-side lookup reads the registered arrays directly, so an update
  // landing on the same index this cycle is only visible from the next one.
  assign w_lk_idx      = bp.pc_i[INDEX_W+1:2];
  assign w_lk_tag      = bp.pc_i[InstAddrBus-1:INDEX_W+2];
  assign w_lk_hit      = bp.ce & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken  = w_lk_hit & r_cnt[w_lk_idx][1];
  assign w_lookup_fire = bp.ce & ~bp.stall_i;

  assign bp.pre_branch_flag_o           = w_pred_taken;
  assign bp.pre_branch_target_address_o = w_pred_taken ? r_target[w_lk_idx] : '0;

  assign w_upd_idx = bp.upd_pc_i[INDEX_W+1:2];
  assign w_upd_tag = bp.upd_pc_i[InstAddrBus-1:INDEX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);

  assign w_mispred = bp.upd_valid_i &
                     is_mispredict(bp.upd_pred_taken_i, bp.upd_pred_target_i,
                                   bp.upd_taken_i, bp.upd_target_i);

  // Byte offset of the word-aligned PCs carries no information.
  assign w_unused = ^{bp.pc_i[1:0], bp.upd_pc_i[1:0]};

  branch_prediction_sat_counter2 u_sat_counter2 (
    .cnt      (r_cnt[w_upd_idx]),
    .up       (bp.upd_taken_i),
    .cnt_next (w_upd_cnt_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CntStrongNT;
      end
    end else if (bp.upd_valid_i) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx] <= w_upd_cnt_next;
        if (bp.upd_taken_i) begin
          r_target[w_upd_idx] <= bp.upd_target_i;
        end
      end else if (bp.upd_taken_i) begin
        // Allocation evicts whatever aliased into this slot.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= bp.upd_target_i;
        r_cnt[w_upd_idx]    <= CntWeakT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lookup_cnt  <= '0;
      r_hit_cnt     <= '0;
      r_mispred_cnt <= '0;
    end else if (bp.perf_clr_i) begin
      r_lookup_cnt  <= '0;
      r_hit_cnt     <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_lookup_fire) begin
        r_lookup_cnt <= r_lookup_cnt + 1'b1;
      end
      if (w_lookup_fire & w_lk_hit) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if (w_mispred) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign bp.lookup_cnt_o  = r_lookup_cnt;
  assign bp.hit_cnt_o     = r_hit_cnt;
  assign bp.mispred_cnt_o = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_prediction.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_branch_prediction                                             |
// | Brief   : Directed scoreboard bench for the branch_prediction BTB.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_branch_prediction;

    localparam int K_FLAG  = 0;
    localparam int K_TGT   = 1;
    localparam int K_LOOK  = 2;
    localparam int K_HIT   = 3;
    localparam int K_MIS   = 4;
    localparam int K_CNT0  = 5;
    localparam int K_VAL0  = 6;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   n_vec;
    int   n_miss;
    int   n_exp;

    branch_prediction_if #(.CNT_W(32)) bp ();

    branch_prediction #(.INDEX_W(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_FLAG:  return {31'd0, bp.pre_branch_flag_o};
            K_TGT:   return bp.pre_branch_target_address_o;
            K_LOOK:  return bp.lookup_cnt_o;
            K_HIT:   return bp.hit_cnt_o;
            K_MIS:   return bp.mispred_cnt_o;
            K_CNT0:  return {30'd0, dut.r_cnt[0]};
            K_VAL0:  return {31'd0, dut.r_valid[0]};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = actual(e.kind);
            n_vec++;
            if (a !== e.val) begin
                n_miss++;
                $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.name = n;
        n_exp++;
        q.push_back(e);
    endtask

    task automatic chk_cnts(input logic [31:0] l, input logic [31:0] h,
                            input logic [31:0] m, input string n);
        chk(K_LOOK, l, {n, "_lookup"});
        chk(K_HIT,  h, {n, "_hit"});
        chk(K_MIS,  m, {n, "_mispred"});
    endtask

    task automatic chk_pred(input logic f, input logic [31:0] t, input string n);
        chk(K_FLAG, {31'd0, f}, {n, "_flag"});
        chk(K_TGT,  t,          {n, "_target"});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bp.ce                = 1'b0;
        bp.pc_i              = '0;
        bp.stall_i           = 1'b0;
        bp.upd_valid_i       = 1'b0;
        bp.upd_pc_i          = '0;
        bp.upd_taken_i       = 1'b0;
        bp.upd_target_i      = '0;
        bp.upd_pred_taken_i  = 1'b0;
        bp.upd_pred_target_i = '0;
        bp.perf_clr_i        = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bp.ce   = 1'b1;
        bp.pc_i = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt);
        bp.upd_valid_i       = 1'b1;
        bp.upd_pc_i          = pc;
        bp.upd_taken_i       = taken;
        bp.upd_target_i      = tgt;
        bp.upd_pred_taken_i  = ptaken;
        bp.upd_pred_target_i = ptgt;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        n_exp  = 0;
        rst    = 1'b0;

        next_cycle(); lookup(32'h100);
        chk_pred(1'b0, 32'h0, "reset"); chk_cnts(0, 0, 0, "reset");
        chk(K_VAL0, 0, "reset_valid0"); chk(K_CNT0, 0, "reset_cnt0");

        next_cycle(); rst = 1'b1; lookup(32'h100);
        chk_pred(1'b0, 32'h0, "cold"); chk(K_LOOK, 0, "cold_lookup");

        next_cycle(); upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        chk(K_LOOK, 1, "after_cold_lookup"); chk(K_HIT, 0, "after_cold_hit");

        next_cycle(); lookup(32'h100);
        chk_pred(1'b1, 32'h200, "trained"); chk_cnts(1, 0, 1, "trained");
        chk(K_CNT0, 2, "alloc_cnt");

        next_cycle(); upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        chk(K_LOOK, 2, "hit_lookup"); chk(K_HIT, 1, "hit_hit");

        next_cycle(); upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        chk(K_CNT0, 3, "inc_to_strong"); chk(K_MIS, 1, "correct_no_mispred");

        next_cycle(); upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        chk(K_CNT0, 3, "sat_high");

        next_cycle(); upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200); lookup(32'h100);
        chk(K_CNT0, 2, "dec_weak_t"); chk_pred(1'b1, 32'h200, "weak_t");

        next_cycle(); upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0); lookup(32'h100);
        chk(K_CNT0, 1, "dec_weak_nt"); chk_pred(1'b0, 32'h0, "weak_nt");
        chk(K_MIS, 3, "dir_mispreds");

        next_cycle(); upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk(K_CNT0, 0, "dec_strong_nt"); chk_cnts(4, 3, 3, "nt_phase");

        next_cycle(); upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
        chk(K_CNT0, 0, "sat_low"); chk(K_VAL0, 1, "nt_entry_valid"); chk(K_MIS, 3, "sat_low_mispred");

        next_cycle(); lookup(32'h100);
        chk_pred(1'b0, 32'h0, "evicted"); chk(K_MIS, 4, "alias_mispred"); chk(K_CNT0, 2, "alias_cnt");

        next_cycle(); lookup(32'h140);
        chk_pred(1'b1, 32'h300, "alias"); chk(K_HIT, 3, "evicted_no_hit");

        next_cycle(); lookup(32'h140); bp.stall_i = 1'b1;
        chk_pred(1'b1, 32'h300, "stalled"); chk_cnts(6, 4, 4, "pre_stall");

        next_cycle(); upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_cnts(6, 4, 4, "post_stall");

        next_cycle(); lookup(32'h100); upd(32'h100, 1'b1, 32'h180, 1'b1, 32'h180);
        chk_pred(1'b0, 32'h0, "conflict_same"); chk(K_CNT0, 2, "nt_miss_no_change");

        next_cycle(); lookup(32'h100);
        chk_pred(1'b1, 32'h180, "conflict_next"); chk_cnts(7, 4, 4, "conflict");

        next_cycle(); bp.pc_i = 32'h100;
        chk_pred(1'b0, 32'h0, "ce_off"); chk_cnts(8, 5, 4, "ce_off");

        next_cycle(); lookup(32'h100); bp.perf_clr_i = 1'b1;
        upd(32'h100, 1'b1, 32'h180, 1'b0, 32'h0);
        chk_cnts(8, 5, 4, "pre_clr");

        next_cycle(); upd(32'h100, 1'b1, 32'h180, 1'b1, 32'h1C0);
        chk_cnts(0, 0, 0, "cleared"); chk(K_CNT0, 3, "clr_update_kept");

        next_cycle(); lookup(32'h100);
        chk_pred(1'b1, 32'h180, "pre_reset"); chk(K_MIS, 1, "target_mispred");

        next_cycle(); lookup(32'h100); upd(32'h240, 1'b1, 32'h400, 1'b0, 32'h0);
        #2; rst = 1'b0;
        #1;
        if (bp.pre_branch_flag_o !== 1'b0) begin
            n_miss++;
            $display("FAIL async_reset_imm_flag: got %b", bp.pre_branch_flag_o);
        end
        if (bp.pre_branch_target_address_o !== 32'h0) begin
            n_miss++;
            $display("FAIL async_reset_imm_target: got %h", bp.pre_branch_target_address_o);
        end
        if (bp.lookup_cnt_o !== 32'h0) begin
            n_miss++;
            $display("FAIL async_reset_imm_lookup: got %h", bp.lookup_cnt_o);
        end
        chk_pred(1'b0, 32'h0, "async_reset"); chk_cnts(0, 0, 0, "async_reset");
        chk(K_VAL0, 0, "async_reset_valid0");

        next_cycle(); rst = 1'b1; lookup(32'h240);
        chk_pred(1'b0, 32'h0, "discarded"); chk(K_VAL0, 0, "discarded_valid0");

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        if (n_vec != n_exp) begin
            $display("FAIL only %0d of %0d expectations were checked", n_vec, n_exp);
            n_miss++;
        end
        if (n_miss != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $finish;
    end

endmodule
`default_nettype wire
